// File: rtl/coin_input_conditioner.sv
// coin_input_conditioner: debounced, edge-detected, buffered coin codes for vending_machine
// Ports: clk system clock; rst async active-low reset; btn_five/btn_ten raw coin buttons;
//        coin_ready downstream accept; coin 2-bit code (00 none, 01 five, 10 ten);
//        coin_valid coin holds a real code; overflow sticky dropped-event flag.
// COIN_FIFO_EN defined: 4-entry FIFO buffer; undefined: single holding register.
module coin_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_five,
    input  logic       btn_ten,
    input  logic       coin_ready,
    output logic [1:0] coin,
    output logic       coin_valid,
    output logic       overflow
);
    logic [1:0] raw, s1, s2, stab, stab_d, press, armed, warm;
    logic [CNT_W-1:0] cnt [2];
    logic pend_v, pend_ten, pend_v_n, pend_ten_n, drop_arb, wr_v, wr_ok, pop, empty, full;
    logic [1:0] wr_code, head;
    assign raw = {btn_ten, btn_five};
    // warm marks s2 as holding real samples; a button only arms once seen released,
    // so a button held through reset release stays silent until re-pressed
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= '0;
            s2 <= '0;
            stab <= '0;
            stab_d <= '0;
            press <= '0;
            armed <= '0;
            warm <= '0;
            cnt[0] <= '0;
            cnt[1] <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            stab_d <= stab;
            warm <= {warm[0], 1'b1};
            press <= stab & ~stab_d & armed;
            for (int i = 0; i < 2; i++) begin
                if (warm[1] && !stab[i] && !s2[i]) armed[i] <= 1'b1;
                if (s2[i] == stab[i]) cnt[i] <= '0;
                else if (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    stab[i] <= s2[i];
                    cnt[i] <= '0;
                end else cnt[i] <= cnt[i] + CNT_W'(1);
            end
        end
    end
    // priority: pending event, then ten, then five; one leftover is held, a second is dropped
    assign wr_v = pend_v | press[1] | press[0];
    assign wr_code = pend_v ? (pend_ten ? 2'b10 : 2'b01) : (press[1] ? 2'b10 : 2'b01);
    assign pend_v_n = pend_v ? (press[1] | press[0]) : (press[1] & press[0]);
    assign pend_ten_n = pend_v & press[1];
    assign drop_arb = pend_v & press[1] & press[0];
    assign pop = !empty && (!coin_valid || coin_ready);
    assign wr_ok = wr_v && (!full || pop);
`ifdef COIN_FIFO_EN
    logic [1:0] mem [4];
    logic [2:0] wp, rp;
    assign empty = (wp == rp);
    assign full = (wp == {~rp[2], rp[1:0]});
    assign head = mem[rp[1:0]];
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp <= '0;
            rp <= '0;
            for (int i = 0; i < 4; i++) mem[i] <= '0;
        end else begin
            if (wr_ok) begin
                mem[wp[1:0]] <= wr_code;
                wp <= wp + 3'd1;
            end
            if (pop) rp <= rp + 3'd1;
        end
    end
`else
    logic hold_v;
    logic [1:0] hold_code;
    assign empty = !hold_v;
    assign full = hold_v;
    assign head = hold_code;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_v <= 1'b0;
            hold_code <= '0;
        end else if (wr_ok) begin
            hold_v <= 1'b1;
            hold_code <= wr_code;
        end else if (pop) begin
            hold_v <= 1'b0;
            hold_code <= '0;
        end
    end
`endif
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_v <= 1'b0;
            pend_ten <= 1'b0;
            overflow <= 1'b0;
            coin <= 2'b00;
            coin_valid <= 1'b0;
        end else begin
            pend_v <= pend_v_n;
            pend_ten <= pend_ten_n;
            overflow <= overflow | drop_arb | (wr_v & ~wr_ok);
            if (!coin_valid || coin_ready) begin
                coin <= empty ? 2'b00 : head;
                coin_valid <= !empty;
            end
        end
    end
endmodule

// File: tb/tb_coin_input_conditioner.sv
// tb_coin_input_conditioner: directed self-checking bench for coin_input_conditioner
module tb_coin_input_conditioner;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic btn_five = 1'b0;
    logic btn_ten = 1'b0;
    logic coin_ready = 1'b1;
    logic [1:0] coin;
    logic coin_valid, overflow;
    int total = 0;
    int bad = 0;
`ifdef COIN_FIFO_EN
    localparam int CAP = 5;
`else
    localparam int CAP = 2;
`endif
    coin_input_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(4)) dut (
        .clk(clk),
        .rst(rst),
        .btn_five(btn_five),
        .btn_ten(btn_ten),
        .coin_ready(coin_ready),
        .coin(coin),
        .coin_valid(coin_valid),
        .overflow(overflow)
    );
    always #5 clk = ~clk;
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic test_reset;
        rst = 1'b0;
        cyc(3);
        total++;
        if (coin !== 2'b00) begin bad++; $display("FAIL reset_coin got=%b want=00", coin); end
        total++;
        if (coin_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", coin_valid); end
        total++;
        if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b want=0", overflow); end
        rst = 1'b1;
        cyc(5);
    endtask
    task automatic test_clean_press;
        logic [1:0] ec;
        int n;
        btn_five = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            cyc(1);
            ec = (k == 9) ? 2'b01 : 2'b00;
            total++;
            if (coin !== ec || coin_valid !== (k == 9)) begin
                bad++;
                $display("FAIL clean_press k=%0d got coin=%b valid=%b want coin=%b valid=%b", k, coin, coin_valid, ec, k == 9);
            end
        end
        btn_five = 1'b0;
        n = 0;
        for (int k = 0; k < 15; k++) begin
            cyc(1);
            if (coin_valid) n++;
        end
        total++;
        if (n != 0) begin bad++; $display("FAIL release_event got=%0d pulses want=0", n); end
    endtask
    task automatic test_bounce;
        int n;
        int badcode;
        btn_ten = 1'b1;
        cyc(3);
        btn_ten = 1'b0;
        n = 0;
        for (int k = 0; k < 15; k++) begin
            cyc(1);
            if (coin_valid) n++;
        end
        total++;
        if (n != 0) begin bad++; $display("FAIL short_glitch got=%0d pulses want=0", n); end
        for (int k = 0; k < 5; k++) begin
            btn_ten = (k % 2 == 0);
            cyc(1);
        end
        n = 0;
        badcode = 0;
        for (int k = 0; k < 25; k++) begin
            cyc(1);
            if (coin_valid) begin
                n++;
                if (coin !== 2'b10) badcode++;
            end
        end
        total++;
        if (n != 1) begin bad++; $display("FAIL bounce_count got=%0d pulses want=1", n); end
        total++;
        if (badcode != 0) begin bad++; $display("FAIL bounce_code got=%0d wrong codes want=0", badcode); end
        btn_ten = 1'b0;
        n = 0;
        for (int k = 0; k < 15; k++) begin
            cyc(1);
            if (coin_valid) n++;
        end
        total++;
        if (n != 0) begin bad++; $display("FAIL bounce_release got=%0d pulses want=0", n); end
    endtask
    task automatic test_simultaneous;
        logic [1:0] ec;
        btn_five = 1'b1;
        btn_ten = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            cyc(1);
            ec = (k == 9) ? 2'b10 : (k == 10) ? 2'b01 : 2'b00;
            total++;
            if (coin !== ec || coin_valid !== (ec != 2'b00)) begin
                bad++;
                $display("FAIL simultaneous k=%0d got coin=%b valid=%b want coin=%b valid=%b", k, coin, coin_valid, ec, ec != 2'b00);
            end
        end
        total++;
        if (overflow !== 1'b0) begin bad++; $display("FAIL simultaneous_overflow got=%b want=0", overflow); end
        btn_five = 1'b0;
        btn_ten = 1'b0;
        cyc(15);
    endtask
    task automatic test_backpressure;
        logic ev;
        coin_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            btn_ten = 1'b1;
            cyc(8);
            btn_ten = 1'b0;
            cyc(8);
            total++;
            if (overflow !== (i + 1 > CAP)) begin
                bad++;
                $display("FAIL bp_overflow press=%0d got=%b want=%b", i + 1, overflow, i + 1 > CAP);
            end
            total++;
            if (coin_valid !== 1'b1 || coin !== 2'b10) begin
                bad++;
                $display("FAIL bp_hold press=%0d got coin=%b valid=%b want coin=10 valid=1", i + 1, coin, coin_valid);
            end
        end
        coin_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) cyc(1);
            ev = (k < CAP);
            total++;
            if (coin_valid !== ev || coin !== (ev ? 2'b10 : 2'b00)) begin
                bad++;
                $display("FAIL bp_drain k=%0d got coin=%b valid=%b want valid=%b", k, coin, coin_valid, ev);
            end
        end
        total++;
        if (overflow !== 1'b1) begin bad++; $display("FAIL bp_sticky got=%b want=1", overflow); end
    endtask
    task automatic test_reset_mid;
        logic [1:0] ec;
        int n;
        coin_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            btn_ten = 1'b1;
            cyc(8);
            btn_ten = 1'b0;
            cyc(8);
        end
        total++;
        if (coin_valid !== 1'b1 || overflow !== (3 > CAP)) begin
            bad++;
            $display("FAIL mid_prefill got valid=%b overflow=%b want valid=1 overflow=%b", coin_valid, overflow, 3 > CAP);
        end
        btn_five = 1'b1;
        cyc(3);
        #2;
        rst = 1'b0;
        #1;
        total++;
        if (coin !== 2'b00 || coin_valid !== 1'b0 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL mid_async_clear got coin=%b valid=%b overflow=%b want 00 0 0", coin, coin_valid, overflow);
        end
        cyc(3);
        rst = 1'b1;
        coin_ready = 1'b1;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            cyc(1);
            if (coin_valid) n++;
        end
        total++;
        if (n != 0) begin bad++; $display("FAIL held_through_reset got=%0d pulses want=0", n); end
        btn_five = 1'b0;
        cyc(12);
        btn_five = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            cyc(1);
            ec = (k == 9) ? 2'b01 : 2'b00;
            total++;
            if (coin !== ec || coin_valid !== (k == 9)) begin
                bad++;
                $display("FAIL repress k=%0d got coin=%b valid=%b want coin=%b valid=%b", k, coin, coin_valid, ec, k == 9);
            end
        end
        btn_five = 1'b0;
        cyc(10);
    endtask
    initial begin
        test_reset;
        test_clean_press;
        test_bounce;
        test_simultaneous;
        test_backpressure;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/coin_input_conditioner.md
# coin_input_conditioner

Front end for `vending_machine`: turns the two raw Basys 3 coin push-buttons into clean, one-per-coin codes on the vending machine's 2-bit `in` input. Handles synchronisation, debounce and press-edge detection. Buffers bursts of coins so none are lost while the downstream stage is not accepting.

## Interface
- `DEBOUNCE_CYCLES`, 1000000: consecutive stable cycles required before a level change is accepted (10 ms at 100 MHz); must be ≥ 2.
- `CNT_W`, 20: debounce counter width; must hold `DEBOUNCE_CYCLES`.
- `clk`  in  1  single system clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset: asserts immediately, released synchronously by the design flow.
- `btn_five`  in  1  raw, asynchronous, bouncing 5-unit coin button, active-high.
- `btn_ten`  in  1  raw, asynchronous, bouncing 10-unit coin button, active-high.
- `coin_ready`  in  1  downstream accepts `coin` this cycle; tie high when driving `vending_machine` directly.
- `coin`  out  2  coin code: 2'b00 none, 2'b01 five, 2'b10 ten; 2'b11 never driven. Connects to `vending_machine.in`.
- `coin_valid`  out  1  `coin` holds a real coin this cycle.
- `overflow`  out  1  sticky: at least one coin event was dropped since reset.

## Operation
- **Synchronise:** two-flop synchroniser per button (`s1`, `s2`).
- **Debounce:**
  - Each button has a registered `stable` level and a `CNT_W` counter.
  - While `s2 == stable`, the counter is 0.
  - While `s2 != stable`, the counter increments.
  - When the counter reaches `DEBOUNCE_CYCLES-1` and `s2` still differs, `stable <= s2` and the counter clears.
  - Any return of `s2` to `stable` clears the counter, so bounce restarts the window.
- **Edge detect:** registered one-cycle `press` pulse on each 0→1 of `stable`. Release (1→0) produces no event.
- **Arbitration:**
  - One FIFO write per cycle.
  - If both `press` pulses are in the same cycle, ten is written first. Five is held in a one-bit pending register and written on the next cycle.
  - A pending five has priority over a new ten or five in that next cycle. A colliding new event is held the same way; a second collision drops the event and sets `overflow`.
- **Buffer:**
  - 4-entry FIFO of 2-bit codes, pointers wrap modulo 4, full/empty via an extra pointer bit.
  - Write when full: the event is dropped, FIFO unchanged, `overflow` set.
- **Output register:**
  - Loads the FIFO head when `coin_valid` is low or (`coin_valid` && `coin_ready`). `coin_valid` is set iff an entry was loaded.
  - When nothing is loaded, `coin <= 2'b00` and `coin_valid <= 0`.
  - `coin` and `coin_valid` never change while `coin_valid && !coin_ready`.
  - Write and pop in the same cycle are legal, including on a full FIFO: the pop frees the slot and the write is accepted.
- **Reset:** every register clears, including mid-debounce, pending, FIFO contents and pointers. Buttons held through reset release produce no event until released and re-pressed.

## Timing
- **Reset values:** `coin = 2'b00`, `coin_valid = 0`, `overflow = 0`, `stable = 0`, counters 0, FIFO empty.
- **Latency:**
  - Let edge E0 be the first clock edge sampling a clean raw high.
  - `stable` rises at edge E0+1+`DEBOUNCE_CYCLES`, `press` at +1, FIFO write at +1, output register at +1.
  - So `coin_valid` is high in the cycle after edge E0+`DEBOUNCE_CYCLES`+4, with FIFO empty and `coin_ready` high.
- **Throughput:** with `coin_ready` high, one coin per cycle. Back-to-back coins appear on consecutive cycles with no 2'b00 gap.
- **Output duration:** each coin is presented for exactly the cycles from `coin_valid` rise to the first cycle with `coin_ready` high, inclusive.

## Configuration
- `COIN_FIFO_EN` defined: the 4-entry FIFO above.
- Undefined: the FIFO is replaced by a single holding register (depth 1). A write while it is occupied and not popping in the same cycle is dropped and sets `overflow`. All other behaviour and latency are identical.

## Test plan
Run with `DEBOUNCE_CYCLES = 4` and `coin_ready = 1` unless stated.
- **Clean press:** reset low 3 cycles, release; raise `btn_five` cleanly → `coin = 2'b01`, `coin_valid = 1` for exactly one cycle, starting the cycle after edge E0+8; nothing on release.
- **Bounce:** toggle `btn_ten` 1,0,1,0,1 on 1-cycle intervals, then hold high → exactly one `coin = 2'b10` pulse; glitches shorter than 4 cycles produce no event.
- **Simultaneous press:** raise `btn_five` and `btn_ten` in the same cycle → `2'b10` then `2'b01` on consecutive cycles; `overflow` stays 0.
- **Backpressure and overflow:** hold `coin_ready = 0`; issue 6 separate ten presses.
  - With `COIN_FIFO_EN`: 5 stored (4 FIFO + output register), `overflow = 1` after the 6th; releasing `coin_ready` yields five `2'b10` cycles.
  - Without `COIN_FIFO_EN`: 2 stored, `overflow = 1` after the 3rd.
- **Reset mid-operation:** assert `rst` low while 3 coins are buffered and a debounce is in progress → `coin = 2'b00`, `coin_valid = 0` and `overflow = 0` immediately, before the next clock edge; after release, no coin is emitted until a fresh press.
